// File: rtl/uart_rx_char.sv
// 8-bit asynchronous serial receiver (8N1) with sticky char/overrun/framing flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_char #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       char_ack,
  output logic [7:0] rx_data,
  output logic       char_rcvd,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              rcvd_q, rcvd_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              rx_s;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
`endif

  // Flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rcvd_d    = rcvd_q & ~char_ack;
    ovr_d     = ovr_q & ~char_ack;
    ferr_d    = ferr_q & ~char_ack;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q & ~char_ack;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StStop;
          // Even parity: data bits plus parity bit must XOR to zero.
          if (rx_s != ^shift_q) begin
            perr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            rcvd_d  = 1'b1;
            state_d = StIdle;
            if (rcvd_q && !char_ack) begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rcvd_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rcvd_q    <= rcvd_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign char_rcvd = rcvd_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_char.sv
// Bench for uart_rx_char: directed and random frames against a frame-level flag model.
module tb_uart_rx_char;

  localparam int unsigned Clks = 16;
  localparam int unsigned Sync = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned Samples = 10;  // 8 data + parity + stop after the start-bit centre
`else
  localparam int unsigned Samples = 9;
`endif
  // Posedges from the line falling (between edges) to the edge that takes the stop sample.
  localparam int unsigned CommitEdge = Sync + 1 + Clks / 2 + Samples * Clks;
  localparam int NomLat = int'(Samples * Clks + Clks / 2 + Sync);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_in;
  logic       char_ack;
  logic [7:0] rx_data;
  logic       char_rcvd;
  logic       overrun;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_char #(
    .CLKS_PER_BIT(Clks),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .char_ack  (char_ack),
    .rx_data   (rx_data),
    .char_rcvd (char_rcvd),
    .overrun   (overrun),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_data;
  logic       exp_rcvd, exp_ovr, exp_ferr, exp_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    check({tag, "_data"}, 32'(rx_data), 32'(exp_data));
    check({tag, "_rcvd"}, 32'(char_rcvd), 32'(exp_rcvd));
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"}, 32'(parity_err), 32'(exp_perr));
`endif
  endtask

  task automatic model_reset();
    exp_data = 8'h00;
    exp_rcvd = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
  endtask

  // Frame-level effect of one received frame; ack marks char_ack on the stop-sample cycle.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok,
                             input logic ack);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) exp_perr = 1'b1;
    if (ack) exp_perr = 1'b0;
`endif
    if (stop_ok) begin
      exp_ovr  = ack ? 1'b0 : (exp_ovr | exp_rcvd);
      exp_ferr = ack ? 1'b0 : exp_ferr;
      exp_rcvd = 1'b1;
      exp_data = b;
    end else begin
      exp_ferr = 1'b1;
      if (ack) begin
        exp_rcvd = 1'b0;
        exp_ovr  = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok);
    rx_in = 1'b0;
    repeat (Clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (Clks) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^b) ^ ~par_ok;
    repeat (Clks) @(negedge clk);
`endif
    rx_in = stop_bit;
    repeat (Clks) @(negedge clk);
  endtask

  task automatic pulse_ack();
    char_ack = 1'b1;
    @(negedge clk);
    char_ack = 1'b0;
    exp_rcvd = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
  endtask

  int   lat;
  logic found;
  logic [7:0] rb;
  logic stop_ok, par_ok;

  initial begin
    reset_n  = 1'b0;
    rx_in    = 1'b1;
    char_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0);
    reset_n = 1'b1;
    idle(4);

    // First byte with latency measured from the falling edge.
    lat   = 0;
    found = 1'b0;
    fork
      send_frame(8'h55, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          lat++;
          if (char_rcvd) found = 1'b1;
        end
      end
    join
    lat = lat - 1;  // posedges from the first edge that saw the low line
    check("latency_in_window", 32'(found && lat >= NomLat - 2 && lat <= NomLat + 2), 32'd1);
    model_frame(8'h55, 1'b1, 1'b1, 1'b0);
    check_all("byte55", 1'b0);

    // Short low glitch is rejected at the mid-start sample.
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    idle(2 * Clks);
    check_all("glitch", 1'b0);

    // Two bytes without ack produce an overrun.
    pulse_ack();
    check_all("ack1", 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1);
    model_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    idle(4);
    send_frame(8'h3C, 1'b1, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_all("overrun", 1'b0);
    pulse_ack();
    check_all("ack2", 1'b0);

    // Stop bit low, line held low: frame error and no false start.
    send_frame(8'h0F, 1'b0, 1'b1);
    model_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check_all("wait_high", 1'b1);
    idle(8);
    check_all("released", 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    model_frame(8'h81, 1'b1, 1'b1, 1'b0);
    check_all("byte81", 1'b0);

    // Ack lands on the commit cycle of a second byte.
    fork
      send_frame(8'h42, 1'b1, 1'b1);
      begin
        repeat (CommitEdge - 1) @(posedge clk);
        @(negedge clk);
        char_ack = 1'b1;
        @(negedge clk);
        char_ack = 1'b0;
      end
    join
    model_frame(8'h42, 1'b1, 1'b1, 1'b1);
    check_all("ack_at_commit", 1'b0);

    // Reset in the middle of the data bits.
    rx_in = 1'b0;
    repeat (Clks) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * Clks) @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid", 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    send_frame(8'hC6, 1'b1, 1'b1);
    model_frame(8'hC6, 1'b1, 1'b1, 1'b0);
    check_all("after_rst", 1'b0);

`ifdef UART_RX_PARITY_EN
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check_all("par_bad", 1'b0);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_all("par_good", 1'b0);
    pulse_ack();
    check_all("par_ack", 1'b0);
`endif

    // Random frames, random bad stops/parity and random acks.
    for (int k = 0; k < 12; k++) begin
      rb      = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      send_frame(rb, stop_ok, par_ok);
      model_frame(rb, stop_ok, par_ok, 1'b0);
      if (!stop_ok) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        check_all("rand_wait", 1'b1);
        idle(8);
      end
      check_all("rand", 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack();
        check_all("rand_ack", 1'b0);
      end
      idle(int'($urandom_range(1, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
